// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_pkg
// Description : Shared types and constants for the nibble-serial adder
//               controller: FSM state encoding, nibble width and the
//               nibble-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index counter. A single-nibble operand still needs
  // a one-bit counter so the signal never collapses to zero width.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : Combinational 4-bit ripple-carry adder slice.
// Ports       : a[3:0], b[3:0], cin  - addends and carry-in
//               s[3:0], cout         - sum and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [NIBBLE:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_bit
    assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[NIBBLE];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Performs WIDTH-bit additions on one shared 4-bit adder slice,
//               one nibble per clock, least-significant nibble first.
// Ports       : clk, rst_n (sync, active-low)
//               req_valid/req_ready, a, b, cin   - operand request
//               rsp_valid/rsp_ready, sum         - result response
//               sub                              - subtract select (SUB_EN)
// Options     : SUB_EN - adds the sub port; sub=1 computes a - b.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SUB_EN
  input  logic             sub,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   sum
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (((WIDTH % NIBBLE) != 0) || (WIDTH < NIBBLE)) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   nib_idx_q, nib_idx_d;
  logic [WIDTH:0]     sum_q, sum_d;

  logic [NIBBLE-1:0]  nib_a, nib_b, nib_s;
  logic               nib_cout;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;

  // Subtraction is a + ~b + 1, so it only changes what gets captured.
`ifdef SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < N; k++) begin
      if (nib_idx_q == IDX_W'(k)) begin
        nib_a = a_q[k*NIBBLE +: NIBBLE];
        nib_b = b_q[k*NIBBLE +: NIBBLE];
      end
    end
  end

  nibble_adder u_nibble_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    nib_idx_d = nib_idx_q;
    sum_d     = sum_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d       = a;
          b_d       = b_in;
          carry_d   = cin_in;
          nib_idx_d = '0;
          sum_d     = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (nib_idx_q == IDX_W'(k)) begin
            sum_d[k*NIBBLE +: NIBBLE] = nib_s;
          end
        end
        carry_d   = nib_cout;
        nib_idx_d = nib_idx_q + IDX_W'(1);
        if (nib_idx_q == LAST_IDX) begin
          sum_d[WIDTH] = nib_cout;
          nib_idx_d    = '0;
          state_d      = DONE;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      nib_idx_q <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      nib_idx_q <= nib_idx_d;
      sum_q     <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule
`default_nettype wire
